// File: rtl/ltc2333_pkg.sv
// Shared constants, register map, FSM encodings and FIFO word layout for the LTC2333 readout controller.
`timescale 1ns/1ps
package ltc2333_pkg;
  localparam int unsigned ADC_BITS = 24;
  localparam int unsigned N_ADC    = 8;
  localparam int unsigned CHIP_W   = 3;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_MASK   = 5'h04;
  localparam logic [4:0] ADDR_SPAN   = 5'h08;
  localparam logic [4:0] ADDR_NCONV  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_DATA   = 5'h14;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CNV   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_PUSH  = 3'd4;

  typedef struct packed {
    logic [CHIP_W-1:0]   chip;
    logic [4:0]          rsvd;
    logic [ADC_BITS-1:0] adc;
  } fifo_word_t;

  // SoftSpan config word: the same 3-bit code for each of the 8 channels
  function automatic logic [ADC_BITS-1:0] span_word(input logic [2:0] span);
    return {(ADC_BITS/3){span}};
  endfunction
endpackage

// File: rtl/ltc2333_fifo.sv
// Synchronous FIFO with occupancy count and clear; push when full is dropped unless a pop frees a slot.
`timescale 1ns/1ps
module ltc2333_fifo #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata_c,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full_c,
  output logic                       empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full_c  = count == CW'(DEPTH);
  assign empty_c = count == '0;
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign rdata_c = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/ltc2333_daq_ctrl.sv
// Burst readout controller for eight LTC2333 ADCs on shared CNV/SCKI/SDI with per-chip SDO.
// Build option LTC_TEST_PATTERN_EN replaces captured SDO data with {chip, conversion index}.
`timescale 1ns/1ps
module ltc2333_daq_ctrl
  import ltc2333_pkg::*;
#(
  parameter int unsigned CNV_HIGH_CYC = 4,
  parameter int unsigned T_CONV_CYC   = 60,
  parameter int unsigned SCK_DIV      = 2,
  parameter int unsigned FIFO_DEPTH   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  reg_addr,
  input  logic        reg_wr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_rd,
  output logic [31:0] reg_rdata,
  output logic        cnv,
  output logic        scki,
  output logic        sdi,
  input  logic [7:0]  sdo
);
  localparam int unsigned TMR_W = 16;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]                       state, next_state;
  logic [TMR_W-1:0]                 tmr;
  logic [4:0]                       bit_cnt;
  logic [CHIP_W-1:0]                chip;
  logic [15:0]                      done;
  logic [7:0]                       mask_r, mask_q;
  logic [2:0]                       span_r, span_q;
  logic [15:0]                      nconv_r, nconv_q;
  logic [N_ADC-1:0][ADC_BITS-1:0]   shreg;
  logic [ADC_BITS-1:0]              sdi_sr, span_bits_c;
  logic                             overflow;
  logic                             start_c, clear_c, tick_c, push_c, pop_c, busy_c;
  logic                             fifo_full_c, fifo_empty_c;
  logic [CNT_W-1:0]                 fifo_count;
  logic [31:0]                      fifo_rdata_c, rd_val_c;
  fifo_word_t                       push_word_c;

  assign start_c     = reg_wr && reg_addr == ADDR_CTRL && reg_wdata[0] && state == ST_IDLE && nconv_r != '0;
  assign clear_c     = reg_wr && reg_addr == ADDR_CTRL && reg_wdata[1];
  assign pop_c       = reg_rd && reg_addr == ADDR_DATA && !fifo_empty_c;
  assign tick_c      = tmr == TMR_W'(SCK_DIV - 1);
  assign busy_c      = state != ST_IDLE;
  assign span_bits_c = span_word(span_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    push_c     = 1'b0;
    case (state)
      ST_IDLE:  if (start_c) next_state = ST_CNV;
      ST_CNV:   if (tmr == TMR_W'(CNV_HIGH_CYC - 1)) next_state = ST_WAIT;
      ST_WAIT:  if (tmr == TMR_W'(T_CONV_CYC - 1)) next_state = ST_SHIFT;
      ST_SHIFT: if (tick_c && scki && bit_cnt == 5'(ADC_BITS - 1)) next_state = ST_PUSH;
      ST_PUSH: begin
        push_c = mask_q[chip];
        if (chip == CHIP_W'(N_ADC - 1))
          next_state = (17'(done) + 17'd1 < 17'(nconv_q)) ? ST_CNV : ST_IDLE;
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    push_word_c      = '0;
    push_word_c.chip = chip;
`ifdef LTC_TEST_PATTERN_EN
    push_word_c.adc  = {chip, 21'(done)};
`else
    push_word_c.adc  = shreg[chip];
`endif
  end

  // Conversion sequencing: CNV pulse, wait, SCKI generation, capture and sdi shift-out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr     <= '0;
      bit_cnt <= '0;
      chip    <= '0;
      done    <= '0;
      cnv     <= 1'b0;
      scki    <= 1'b0;
      sdi     <= 1'b0;
      sdi_sr  <= '0;
      shreg   <= '0;
      mask_q  <= '0;
      span_q  <= '0;
      nconv_q <= '0;
    end else begin
      if (next_state != state || state == ST_IDLE || (state == ST_SHIFT && tick_c)) tmr <= '0;
      else tmr <= tmr + TMR_W'(1);
      cnv <= next_state == ST_CNV;
      if (start_c) begin
        mask_q  <= mask_r;
        span_q  <= span_r;
        nconv_q <= nconv_r;
        done    <= '0;
      end else if (state == ST_PUSH && chip == CHIP_W'(N_ADC - 1)) begin
        done <= done + 16'd1;
      end
      chip <= (state == ST_PUSH) ? chip + CHIP_W'(1) : '0;
      if (state == ST_WAIT && next_state == ST_SHIFT) begin
        bit_cnt <= '0;
        scki    <= 1'b0;
        sdi     <= span_bits_c[ADC_BITS-1];
        sdi_sr  <= span_bits_c << 1;
      end else if (state == ST_SHIFT && tick_c) begin
        scki <= ~scki;
        if (!scki) begin
          for (int unsigned i = 0; i < N_ADC; i++) shreg[i] <= {shreg[i][ADC_BITS-2:0], sdo[i]};
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
          sdi     <= sdi_sr[ADC_BITS-1];
          sdi_sr  <= sdi_sr << 1;
        end
      end
    end
  end

  always_comb begin
    rd_val_c = '0;
    case (reg_addr)
      ADDR_MASK:   rd_val_c = 32'(mask_r);
      ADDR_SPAN:   rd_val_c = 32'(span_r);
      ADDR_NCONV:  rd_val_c = 32'(nconv_r);
      ADDR_STATUS: rd_val_c = (32'(fifo_count) << 16) | {28'd0, overflow, fifo_full_c, fifo_empty_c, busy_c};
      ADDR_DATA:   if (!fifo_empty_c) rd_val_c = fifo_rdata_c;
      default:     rd_val_c = '0;
    endcase
  end

  // Register file, sticky overflow and registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r    <= 8'hFF;
      span_r    <= 3'b111;
      nconv_r   <= '0;
      overflow  <= 1'b0;
      reg_rdata <= '0;
    end else begin
      if (reg_wr && reg_addr == ADDR_MASK)  mask_r  <= reg_wdata[7:0];
      if (reg_wr && reg_addr == ADDR_SPAN)  span_r  <= reg_wdata[2:0];
      if (reg_wr && reg_addr == ADDR_NCONV) nconv_r <= reg_wdata[15:0];
      if (clear_c) overflow <= 1'b0;
      else if (push_c && fifo_full_c && !pop_c) overflow <= 1'b1;
      reg_rdata <= reg_rd ? rd_val_c : '0;
    end
  end

  ltc2333_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_c),
    .push    (push_c),
    .wdata   (push_word_c),
    .pop     (pop_c),
    .rdata_c (fifo_rdata_c),
    .count   (fifo_count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );
endmodule

// File: tb/tb_ltc2333_daq_ctrl.sv
// Self-checking bench for ltc2333_daq_ctrl: behavioural ADC shift models plus a scoreboard of expected FIFO words.
`timescale 1ns/1ps
module tb_ltc2333_daq_ctrl;
  logic        tb_ACLK;
  logic        reset;
  logic [4:0]  reg_addr;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        cnv, scki, sdi;
  logic [7:0]  sdo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [23:0] adc_word [8];
  logic [23:0] adc_sh [8];
  int          cnv_hi = 0;
  int          rises  = 0;
  logic [23:0] sdi_cap = '0;

  ltc2333_daq_ctrl dut (
    .clk       (tb_ACLK),
    .reset     (reset),
    .reg_addr  (reg_addr),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .cnv       (cnv),
    .scki      (scki),
    .sdi       (sdi),
    .sdo       (sdo)
  );

  initial begin
    tb_ACLK = 1'b0;
    forever #5 tb_ACLK = ~tb_ACLK;
  end

  // ADC model: word loaded on CNV rise, MSB presented first, next bit after each SCKI fall
  always @(posedge cnv or negedge scki) begin
    for (int i = 0; i < 8; i++) adc_sh[i] <= cnv ? adc_word[i] : {adc_sh[i][22:0], 1'b0};
  end
  always_comb begin
    for (int i = 0; i < 8; i++) sdo[i] = adc_sh[i][23];
  end

  always @(negedge tb_ACLK) if (cnv) cnv_hi <= cnv_hi + 1;
  always @(posedge scki) begin
    rises   <= rises + 1;
    sdi_cap <= {sdi_cap[22:0], sdi};
  end

  initial begin
    #3ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input int chip, input int conv);
    logic [23:0] a;
`ifdef LTC_TEST_PATTERN_EN
    a = {3'(chip), 21'(conv)};
`else
    a = adc_word[chip] ^ 24'(conv * 0);
`endif
    return {3'(chip), 5'b0, a};
  endfunction

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge tb_ACLK);
    reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
    @(negedge tb_ACLK);
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge tb_ACLK);
    reg_addr = a; reg_rd = 1'b1;
    @(negedge tb_ACLK);
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic start_burst(input logic [7:0] mask, input logic [15:0] nconv);
    reg_write(5'h04, 32'(mask));
    reg_write(5'h0C, 32'(nconv));
    reg_write(5'h00, 32'h1);
    for (int c = 0; c < int'(nconv); c++)
      for (int ch = 0; ch < 8; ch++)
        if (mask[ch] && exp_q.size() < 256) exp_q.push_back(exp_word(ch, c));
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] s;
    int polls = 0;
    do begin
      reg_read(5'h10, s);
      polls++;
    end while (s[0] && polls < 20000);
    ok = !s[0];
  endtask

  task automatic pop_data(output logic [31:0] got, output logic [31:0] exp);
    reg_read(5'h14, got);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] s;
    reset = 1'b1;
    repeat (3) @(negedge tb_ACLK);
    n_checks++;
    if ({cnv, scki, sdi} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pins got %b exp 000", {cnv, scki, sdi});
    end
    n_checks++;
    if (reg_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h exp 00000000", reg_rdata);
    end
    reset = 1'b0;
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h2) begin n_fail++; $display("FAIL reset_status got %h exp 00000002", s); end
  endtask

  task automatic test_full_burst();
    logic [31:0] s, got, exp;
    bit ok;
    for (int i = 0; i < 8; i++) adc_word[i] = 24'hABCDE5;
    start_burst(8'hFF, 16'h10);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_burst_idle busy never cleared"); end
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h0080_0000) begin n_fail++; $display("FAIL full_burst_status got %h exp 00800000", s); end
    for (int k = 0; k < 128; k++) begin
      pop_data(got, exp);
      n_checks++;
      if (got !== exp || got[23:0] !== 24'hABCDE5) begin
        n_fail++; $display("FAIL full_burst_data[%0d] got %h exp %h", k, got, exp);
      end
    end
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h2) begin n_fail++; $display("FAIL full_burst_drained got %h exp 00000002", s); end
  endtask

  task automatic test_mask();
    logic [31:0] s, got, exp;
    bit ok;
    int chips[4] = '{0, 2, 0, 2};
    for (int i = 0; i < 8; i++) adc_word[i] = 24'h135000 + 24'(i * 24'h10101);
    start_burst(8'h05, 16'd2);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mask_idle busy never cleared"); end
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h0004_0000) begin n_fail++; $display("FAIL mask_status got %h exp 00040000", s); end
    for (int k = 0; k < 4; k++) begin
      pop_data(got, exp);
      n_checks++;
      if (got !== exp || int'(got[31:29]) != chips[k]) begin
        n_fail++; $display("FAIL mask_data[%0d] got %h exp %h chip %0d", k, got, exp, chips[k]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] s, got, exp;
    bit ok;
    start_burst(8'hFF, 16'd40);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ovf_idle busy never cleared"); end
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h0100_000C) begin n_fail++; $display("FAIL ovf_status got %h exp 0100000C", s); end
    for (int k = 0; k < 3; k++) begin
      pop_data(got, exp);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ovf_data[%0d] got %h exp %h", k, got, exp); end
    end
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h00FD_0008) begin n_fail++; $display("FAIL ovf_sticky got %h exp 00FD0008", s); end
    reg_write(5'h00, 32'h2);
    exp_q.delete();
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h2) begin n_fail++; $display("FAIL ovf_clear got %h exp 00000002", s); end
  endtask

  task automatic test_spi_timing();
    logic [31:0] got, exp;
    int cnv_base, rise_base;
    bit ok;
    adc_word[0] = 24'h5A3C96;
    reg_write(5'h08, 32'h5);
    cnv_base = cnv_hi; rise_base = rises;
    start_burst(8'h01, 16'd1);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL spi_idle busy never cleared"); end
    n_checks++;
    if (cnv_hi - cnv_base != 4) begin n_fail++; $display("FAIL spi_cnv_width got %0d exp 4", cnv_hi - cnv_base); end
    n_checks++;
    if (rises - rise_base != 24) begin n_fail++; $display("FAIL spi_scki_rises got %0d exp 24", rises - rise_base); end
    n_checks++;
    if (sdi_cap !== 24'hB6DB6D) begin n_fail++; $display("FAIL spi_sdi_word got %h exp B6DB6D", sdi_cap); end
    n_checks++;
    if (scki !== 1'b0) begin n_fail++; $display("FAIL spi_scki_idle got %b exp 0", scki); end
    pop_data(got, exp);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL spi_data got %h exp %h", got, exp); end
  endtask

  task automatic test_empty_and_busy();
    logic [31:0] s, got, exp;
    bit ok;
    reg_read(5'h14, got);
    n_checks++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL empty_data got %h exp 00000000", got); end
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h2) begin n_fail++; $display("FAIL empty_status got %h exp 00000002", s); end
    reg_write(5'h0C, 32'h0);
    reg_write(5'h00, 32'h1);
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h2) begin n_fail++; $display("FAIL nconv0_start got %h exp 00000002", s); end
    adc_word[0] = 24'h0F1E2D;
    start_burst(8'h01, 16'd3);
    reg_write(5'h00, 32'h1);
    repeat (200) @(negedge tb_ACLK);
    reg_write(5'h00, 32'h1);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL busy_idle busy never cleared"); end
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h0003_0000) begin n_fail++; $display("FAIL busy_start_count got %h exp 00030000", s); end
    for (int k = 0; k < 3; k++) begin
      pop_data(got, exp);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL busy_data[%0d] got %h exp %h", k, got, exp); end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] s;
    start_burst(8'hFF, 16'd5);
    repeat (100) @(negedge tb_ACLK);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({cnv, scki, sdi} !== 3'b000) begin
      n_fail++; $display("FAIL abort_pins got %b exp 000", {cnv, scki, sdi});
    end
    @(negedge tb_ACLK);
    reset = 1'b0;
    exp_q.delete();
    reg_read(5'h10, s);
    n_checks++;
    if (s !== 32'h2) begin n_fail++; $display("FAIL abort_status got %h exp 00000002", s); end
    reg_read(5'h04, s);
    n_checks++;
    if (s !== 32'hFF) begin n_fail++; $display("FAIL abort_mask got %h exp 000000FF", s); end
  endtask

  initial begin
    reset = 1'b1; reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0; reg_rd = 1'b0;
    for (int i = 0; i < 8; i++) adc_word[i] = '0;
    test_reset();
    test_full_burst();
    test_mask();
    test_overflow();
    test_spi_timing();
    test_empty_and_busy();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
